seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 8, number of multiplexed digits (legal 1..16).
REQ-002 Parameter SCAN_DIV, default 100000, clock cycles per digit slot (legal >= 4).
REQ-003 Parameter BRIGHT_W, default 4, brightness control width.
REQ-004 Parameter LZ_SUPPRESS, default 0, 1 enables leading-zero blanking.
REQ-005 clk  in  1  sole clock, all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 digits  in  4*N_DIGITS  hex nibbles, nibble i drives digit i (digit 0 rightmost).
REQ-008 dp_in  in  N_DIGITS  decimal point per digit, 1 = lit.
REQ-009 blank  in  N_DIGITS  per-digit force-off, 1 = blanked.
REQ-010 load  in  1  one-cycle strobe capturing digits/dp_in/blank into the pending buffer.
REQ-011 brightness  in  BRIGHT_W  duty control; 0 = dark, all-ones = full.
REQ-012 enable  out  N_DIGITS  digit select, active-low, at most one bit low.
REQ-013 segment  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 dp  out  1  decimal point, active-low.
REQ-015 frame_done  out  1  one-cycle pulse when the last digit slot ends.

Function
REQ-016 Prescaler counts 0..SCAN_DIV-1 and wraps; a wrap advances digit index 0..N_DIGITS-1, wrapping to 0.
REQ-017 load captures inputs into pending; pending copies to active only on the cycle index wraps N_DIGITS-1 -> 0 (no mid-frame tearing); multiple loads within a frame: last wins.
REQ-018 load on the same cycle as the frame wrap: active takes the old pending; new values appear next frame.
REQ-019 Decode: 0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 4->7'h19, 5->7'h12, 6->7'h02, 7->7'h78, 8->7'h00, 9->7'h10, A->7'h08, b->7'h03, C->7'h46, d->7'h21, E->7'h06, F->7'h0E.
REQ-020 Dead time: enable all-high during prescaler counts 0 and 1 of every slot.
REQ-021 PWM counter (BRIGHT_W bits) free-runs every clk; digit lit only when pwm_cnt < brightness, or brightness is all-ones.
REQ-022 Digit lit only if outside dead time, PWM-on, blank bit 0, and not leading-zero-suppressed; otherwise its enable is high.
REQ-023 LZ_SUPPRESS=1: digits above the highest non-zero nibble are suppressed; digit 0 never suppressed; a digit with its dp bit set is never suppressed.
REQ-024 segment and dp are registered from the active buffer at the current index and change only during dead time; output latency 1 cycle from index change.
REQ-025 frame_done asserts for exactly the cycle the index wraps to 0.
REQ-026 brightness is sampled every cycle (no buffering); changes take effect within one PWM period.

Reset
REQ-027 rst forces: enable all-ones, segment 7'h7F, dp 1, frame_done 0.
REQ-028 rst clears prescaler, index, PWM counter, pending and active buffers (digits 0, dp 0, blank 0).
REQ-029 rst mid-frame restarts at index 0, prescaler 0 on the following cycle; load coincident with rst is ignored.

Structure
REQ-030 Package seg7_pkg holds the 16-entry segment table constant, segment-bit index constants and parameter defaults.
REQ-031 One sub-module seg7_decode (4-bit nibble -> 7-bit active-low pattern, combinational) is instantiated once.

Verification (N_DIGITS=4, SCAN_DIV=4, BRIGHT_W=2 unless stated)
REQ-032 rst, load digits=16'h73F0, brightness=2'b11 -> per frame enable 4'b1110/1101/1011/0111 with segment 7'h40, 7'h0E, 7'h30, 7'h78; enable 4'hF on slot counts 0-1.
REQ-033 Load 16'h1234 mid-frame (index 1) -> remainder of frame shows old digits; new digits from the slot after frame_done.
REQ-034 brightness=2'b01 -> each enable low 1 of every 4 cycles outside dead time; brightness=0 -> enable stays 4'hF.
REQ-035 LZ_SUPPRESS=1, digits=16'h0050, dp_in=4'b1000 -> digits 0,1 lit, digit 2 suppressed, digit 3 lit with segment 7'h40 and dp 0.
REQ-036 blank=4'b0100 -> digit 2 enable never low; frame_done pulses once every 16 cycles.
REQ-037 rst asserted at index 2 -> next cycle all outputs at reset values; scan resumes at index 0.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared constants for the multiplexed 7-segment scan controller:
//   parameter defaults, the segment bit range and the hex-to-segment table.
//   Segment vectors are ordered {g,f,e,d,c,b,a}. Bit a is the LSB. All
//   patterns are active-low: 0 = segment lit.
// ---------------------------------------------------------------------------
package seg7_pkg;

  // Default parameter values for seg7_scan_ctrl
  localparam int N_DIGITS_DEF    = 8;
  localparam int SCAN_DIV_DEF    = 100000;
  localparam int BRIGHT_W_DEF    = 4;
  localparam bit LZ_SUPPRESS_DEF = 1'b0;

  // Segment bit positions inside a pattern: a is bit 0, g is bit 6
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  typedef logic [SEG_G:SEG_A] seg_pattern_t;

  // Every segment dark
  localparam seg_pattern_t SEG_BLANK = 7'h7F;

  // Active-low hex glyphs. The concatenation is listed from entry F down
  // to entry 0, so SEG_TABLE[n] is the glyph for nibble n.
  localparam logic [15:0][SEG_G:SEG_A] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl_if
//   Bundle of the display-data inputs and the LED-driving outputs of
//   seg7_scan_ctrl.
//     digits     : 4*N_DIGITS hex nibbles, nibble i -> digit i (0 = rightmost)
//     dp_in      : per-digit decimal point request, 1 = lit
//     blank      : per-digit force-off, 1 = blanked
//     load       : one-cycle strobe, captures digits/dp_in/blank
//     brightness : PWM duty, 0 = dark, all-ones = full
//     enable     : digit select, active-low, at most one bit low
//     segment    : {g,f,e,d,c,b,a}, active-low
//     dp         : decimal point, active-low
//     frame_done : one-cycle pulse at the start of each new frame
//   master : the side that supplies display data (host / testbench)
//   slave  : the scan controller
// ---------------------------------------------------------------------------
interface seg7_scan_ctrl_if #(
  parameter int N_DIGITS = seg7_pkg::N_DIGITS_DEF,
  parameter int BRIGHT_W = seg7_pkg::BRIGHT_W_DEF
);

  logic [4*N_DIGITS-1:0]               digits;
  logic [N_DIGITS-1:0]                 dp_in;
  logic [N_DIGITS-1:0]                 blank;
  logic                                load;
  logic [BRIGHT_W-1:0]                 brightness;
  logic [N_DIGITS-1:0]                 enable;
  logic [seg7_pkg::SEG_G:seg7_pkg::SEG_A] segment;
  logic                                dp;
  logic                                frame_done;

  modport master (
    output digits, dp_in, blank, load, brightness,
    input  enable, segment, dp, frame_done
  );

  modport slave (
    input  digits, dp_in, blank, load, brightness,
    output enable, segment, dp, frame_done
  );

endinterface

// File: rtl/seg7_scan_ctrl_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
//   Combinational hex nibble to active-low 7-segment glyph.
//     nibble_i : 4-bit value 0..F
//     seg_o    : {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]         nibble_i,
  output logic [SEG_G:SEG_A] seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed driver for an N_DIGITS common-anode style 7-segment
//   display with double-buffered data, dead time between slots, PWM
//   brightness and optional leading-zero blanking.
//   Ports:
//     clk : sole clock, rising edge
//     rst : synchronous active-high reset
//     bus : seg7_scan_ctrl_if.slave (display data in, LED drive out)
//   Parameters:
//     N_DIGITS    : digits scanned, 1..16
//     SCAN_DIV    : clock cycles per digit slot, >= 4
//     BRIGHT_W    : width of the brightness control
//     LZ_SUPPRESS : 1 blanks digits above the highest non-zero nibble
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = N_DIGITS_DEF,
  parameter int SCAN_DIV    = SCAN_DIV_DEF,
  parameter int BRIGHT_W    = BRIGHT_W_DEF,
  parameter bit LZ_SUPPRESS = LZ_SUPPRESS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;

  logic [4*N_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_d;

  logic [4*N_DIGITS-1:0] act_dig_q, act_dig_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]   act_blank_q, act_blank_d;

  logic [N_DIGITS-1:0]   enable_q, enable_d;
  seg_pattern_t          seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  // ---------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------
  logic presc_wrap;
  logic idx_last;
  logic frame_wrap;

  always_comb begin
    presc_wrap = (presc_q == PRESC_W'(SCAN_DIV - 1));
    idx_last   = (idx_q == IDX_W'(N_DIGITS - 1));
    frame_wrap = presc_wrap && idx_last;

    presc_d = presc_wrap ? '0 : presc_q + 1'b1;

    idx_d = idx_q;
    if (presc_wrap) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end

    pwm_d        = pwm_q + 1'b1;
    frame_done_d = frame_wrap;
  end

  // ---------------------------------------------------------------------
  // Double buffer. A load on the frame-wrap cycle lands in pending while
  // active takes the previous pending contents, so the new data shows one
  // frame later and a frame is never drawn from mixed data.
  // ---------------------------------------------------------------------
  always_comb begin
    pend_dig_d   = bus.load ? bus.digits : pend_dig_q;
    pend_dp_d    = bus.load ? bus.dp_in  : pend_dp_q;
    pend_blank_d = bus.load ? bus.blank  : pend_blank_q;

    act_dig_d   = frame_wrap ? pend_dig_q   : act_dig_q;
    act_dp_d    = frame_wrap ? pend_dp_q    : act_dp_q;
    act_blank_d = frame_wrap ? pend_blank_q : act_blank_q;
  end

  // Per-digit nibble views of the active buffer, current and next state
  logic [3:0] nib_q [N_DIGITS];
  logic [3:0] nib_d [N_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_nib
      assign nib_q[gi] = act_dig_q[4*gi +: 4];
      assign nib_d[gi] = act_dig_d[4*gi +: 4];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Leading-zero suppression, evaluated on the buffer that will be live
  // next cycle so it lines up with the registered enable.
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]    hi_nz;
  logic [N_DIGITS-1:0] supp;

  always_comb begin
    hi_nz = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (nib_d[i] != 4'h0) begin
        hi_nz = IDX_W'(i);
      end
    end
  end

  // Digit 0 can never satisfy hi_nz < 0, so it is never suppressed.
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_supp
      assign supp[gi] = LZ_SUPPRESS && (hi_nz < IDX_W'(gi)) && !act_dp_d[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Digit enables. Computed from next-state values so the registered
  // enable is aligned with the prescaler count it belongs to: high for
  // counts 0 and 1 of every slot, which hides the segment change.
  // ---------------------------------------------------------------------
  logic live_d;
  logic pwm_on;

  always_comb begin
    live_d = (presc_d >= PRESC_W'(2));
    pwm_on = (&bus.brightness) || (pwm_d < bus.brightness);
  end

  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_en
      assign enable_d[gi] = ~(live_d && pwm_on &&
                              (idx_d == IDX_W'(gi)) &&
                              !act_blank_d[gi] && !supp[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Segment / decimal point: registered from the current slot, so a new
  // glyph appears one cycle after the index moves, still inside dead time.
  // ---------------------------------------------------------------------
  seg_pattern_t cur_glyph;

  seg7_decode u_decode (
    .nibble_i (nib_q[idx_q]),
    .seg_o    (cur_glyph)
  );

  always_comb begin
    seg_d = cur_glyph;
    dp_d  = ~act_dp_q[idx_q];
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      enable_q     <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      enable_q     <= enable_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.enable     = enable_q;
  assign bus.segment    = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//   Three controllers share one stimulus stream:
//     a : SCAN_DIV 4, no leading-zero blanking
//     b : SCAN_DIV 4, leading-zero blanking
//     c : SCAN_DIV 5, no leading-zero blanking (PWM not phase-locked to slots)
//   A cycle-count model built from the display rules predicts every output
//   of every controller on every clock.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int BW = 2;
  localparam int NI = 3;
  localparam int SDIV [NI] = '{4, 4, 5};
  localparam bit LZ   [NI] = '{1'b0, 1'b1, 1'b0};

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4*ND-1:0] digits;
  logic [ND-1:0]   dp_in;
  logic [ND-1:0]   blank;
  logic            load;
  logic [BW-1:0]   brightness;

  seg7_scan_ctrl_if #(.N_DIGITS(ND), .BRIGHT_W(BW)) bus_a ();
  seg7_scan_ctrl_if #(.N_DIGITS(ND), .BRIGHT_W(BW)) bus_b ();
  seg7_scan_ctrl_if #(.N_DIGITS(ND), .BRIGHT_W(BW)) bus_c ();

  assign bus_a.digits = digits;  assign bus_a.dp_in = dp_in;  assign bus_a.blank = blank;
  assign bus_a.load   = load;    assign bus_a.brightness = brightness;
  assign bus_b.digits = digits;  assign bus_b.dp_in = dp_in;  assign bus_b.blank = blank;
  assign bus_b.load   = load;    assign bus_b.brightness = brightness;
  assign bus_c.digits = digits;  assign bus_c.dp_in = dp_in;  assign bus_c.blank = blank;
  assign bus_c.load   = load;    assign bus_c.brightness = brightness;

  seg7_scan_ctrl #(.N_DIGITS(ND), .SCAN_DIV(4), .BRIGHT_W(BW), .LZ_SUPPRESS(1'b0)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  seg7_scan_ctrl #(.N_DIGITS(ND), .SCAN_DIV(4), .BRIGHT_W(BW), .LZ_SUPPRESS(1'b1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );
  seg7_scan_ctrl #(.N_DIGITS(ND), .SCAN_DIV(5), .BRIGHT_W(BW), .LZ_SUPPRESS(1'b0)) dut_c (
    .clk (clk), .rst (rst), .bus (bus_c)
  );

  logic [ND-1:0] en_o  [NI];
  logic [6:0]    seg_o [NI];
  logic          dp_o  [NI];
  logic          fd_o  [NI];

  assign en_o[0] = bus_a.enable;  assign seg_o[0] = bus_a.segment;
  assign dp_o[0] = bus_a.dp;      assign fd_o[0]  = bus_a.frame_done;
  assign en_o[1] = bus_b.enable;  assign seg_o[1] = bus_b.segment;
  assign dp_o[1] = bus_b.dp;      assign fd_o[1]  = bus_b.frame_done;
  assign en_o[2] = bus_c.enable;  assign seg_o[2] = bus_c.segment;
  assign dp_o[2] = bus_c.dp;      assign fd_o[2]  = bus_c.frame_done;

  // ---------------------------------------------------------------------
  // Reference model: n = clocks since reset; slot, prescaler and PWM phase
  // follow from n by division. Pending is shared, active is per controller
  // because frame boundaries differ with SCAN_DIV.
  // ---------------------------------------------------------------------
  int            n;
  logic [15:0]   pend_dig;
  logic [3:0]    pend_dp, pend_bl;
  logic [15:0]   act_dig [NI];
  logic [3:0]    act_dp  [NI];
  logic [3:0]    act_bl  [NI];
  logic [3:0]    x_en    [NI];
  logic [6:0]    x_seg   [NI];
  logic          x_dp    [NI];
  logic          x_fd    [NI];

  int n_cmp;
  int n_bad;
  int fd_cnt [2];

  // Expected enable of controller k while it sits at clock count m
  function automatic logic [3:0] exp_en(input int k, input int m);
    int   s;
    int   cur;
    int   hi;
    logic lit;
    logic [3:0] e;
    s   = SDIV[k];
    cur = (m / s) % ND;
    hi  = 0;
    e   = 4'hF;
    for (int i = 0; i < ND; i++) begin
      if (act_dig[k][4*i +: 4] != 4'h0) hi = i;
    end
    lit = ((m % s) >= 2) &&
          ((brightness == 2'b11) || ((m % 4) < int'(brightness))) &&
          !act_bl[k][cur] &&
          !(LZ[k] && (cur > hi) && !act_dp[k][cur]);
    if (lit) e[cur] = 1'b0;
    return e;
  endfunction

  task automatic check(input string tag, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $display("FAIL %s dut%0d n=%0d got=%0h want=%0h", tag, k, n, got, exp);
      $error("%s dut%0d differs from model", tag, k);
    end
  endtask

  // One clock: advance the model across the edge, then compare all outputs.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        act_dig[k] = '0;
        act_dp[k]  = '0;
        act_bl[k]  = '0;
        x_en[k]    = 4'hF;
        x_seg[k]   = 7'h7F;
        x_dp[k]    = 1'b1;
        x_fd[k]    = 1'b0;
      end else begin
        int s;
        int cur;
        logic wrap;
        s    = SDIV[k];
        cur  = (n / s) % ND;
        wrap = (((n + 1) % (s * ND)) == 0);
        x_seg[k] = SEG_REF[act_dig[k][4*cur +: 4]];
        x_dp[k]  = ~act_dp[k][cur];
        x_fd[k]  = wrap;
        if (wrap) begin
          act_dig[k] = pend_dig;
          act_dp[k]  = pend_dp;
          act_bl[k]  = pend_bl;
        end
        x_en[k] = exp_en(k, n + 1);
      end
    end
    if (rst) begin
      n        = 0;
      pend_dig = '0;
      pend_dp  = '0;
      pend_bl  = '0;
    end else begin
      if (load) begin
        pend_dig = digits;
        pend_dp  = dp_in;
        pend_bl  = blank;
      end
      n++;
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      check("enable",     k, 32'(en_o[k]),  32'(x_en[k]));
      check("segment",    k, 32'(seg_o[k]), 32'(x_seg[k]));
      check("dp",         k, 32'(dp_o[k]),  32'(x_dp[k]));
      check("frame_done", k, 32'(fd_o[k]),  32'(x_fd[k]));
    end
    load = 1'b0;
  endtask

  initial begin
    n = 0;  n_cmp = 0;  n_bad = 0;
    pend_dig = '0;  pend_dp = '0;  pend_bl = '0;
    digits = '0;  dp_in = '0;  blank = '0;  load = 1'b0;  brightness = '0;
    rst = 1'b1;

    $display("phase: reset");
    repeat (3) step();
    rst = 1'b0;

    $display("phase: full brightness 73F0");
    digits = 16'h73F0;  brightness = 2'b11;  load = 1'b1;
    step();
    repeat (48) step();

    $display("phase: mid-frame load 1234");
    for (int i = 0; i < 64 && ((n / 4) % ND) != 1; i++) step();
    digits = 16'h1234;  load = 1'b1;
    step();
    repeat (40) step();

    $display("phase: dimmed");
    brightness = 2'b01;  repeat (32) step();
    brightness = 2'b10;  repeat (32) step();
    brightness = 2'b00;  repeat (32) step();

    $display("phase: leading zeros 0050 dp 1000");
    brightness = 2'b11;  digits = 16'h0050;  dp_in = 4'b1000;  load = 1'b1;
    step();
    repeat (48) step();

    $display("phase: blank digit 2, frame rate");
    digits = 16'h8888;  dp_in = 4'b0000;  blank = 4'b0100;  load = 1'b1;
    step();
    repeat (20) step();
    fd_cnt[0] = 0;  fd_cnt[1] = 0;
    repeat (64) begin
      step();
      if (fd_o[0] === 1'b1) fd_cnt[0]++;
      if (fd_o[1] === 1'b1) fd_cnt[1]++;
    end
    check("fd_per_64", 0, 32'(fd_cnt[0]), 32'd4);
    check("fd_per_64", 1, 32'(fd_cnt[1]), 32'd4);

    $display("phase: reset at index 2 with coincident load");
    blank = 4'b0000;
    for (int i = 0; i < 64 && ((n / 4) % ND) != 2; i++) step();
    step();
    rst = 1'b1;  digits = 16'hABCD;  load = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();

    $display("phase: random");
    repeat (900) begin
      if ($urandom_range(0, 5) == 0) begin
        digits = 16'($urandom) >> (4 * $urandom_range(0, 3));
        dp_in  = 4'($urandom & $urandom);
        blank  = 4'($urandom & $urandom & $urandom);
        load   = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) brightness = 2'($urandom);
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
